// File: rtl/id_hazard_unit_pkg.sv
// id_hazard_unit_pkg: shared MDU state encoding, default latencies and register-0 constant
package id_hazard_unit_pkg;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_hazard_unit_df_port_sel.sv
// df_port_sel: per-source forwarding mux and load-use hazard detect
module df_port_sel
  import id_hazard_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSTG = 2
) (
  input  logic [4:0]           addr,
  input  logic                 rena,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [NSTG-1:0]      stg_valid,
  input  logic [NSTG-1:0]      stg_rf_wena,
  input  logic [NSTG-1:0]      stg_rf_ready,
  input  logic [5*NSTG-1:0]    stg_rf_waddr,
  input  logic [XLEN*NSTG-1:0] stg_rf_wdata,
  output logic [XLEN-1:0]      data,
  output logic                 hazard
);

  // scan oldest to youngest so the youngest match wins; its ready flag alone decides the hazard
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    for (int i = NSTG - 1; i >= 0; i--)
      if (stg_valid[i] && stg_rf_wena[i] && rena && addr != REG_ZERO &&
          stg_rf_waddr[5*i +: 5] == addr) begin
        data   = stg_rf_wdata[XLEN*i +: XLEN];
        hazard = ~stg_rf_ready[i];
      end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: ID-stage operand forwarding, load-use and MDU interlock, stall counter
module id_hazard_unit
  import id_hazard_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NSTG    = 2,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           rs_addr,
  input  logic [4:0]           rt_addr,
  input  logic                 rs_rena,
  input  logic                 rt_rena,
  input  logic [XLEN-1:0]      rs_rf,
  input  logic [XLEN-1:0]      rt_rf,
  input  logic                 hi_rd,
  input  logic                 lo_rd,
  input  logic [XLEN-1:0]      hi_reg,
  input  logic [XLEN-1:0]      lo_reg,
  input  logic                 mdu_issue,
  input  logic                 mdu_div,
  input  logic [NSTG-1:0]      stg_valid,
  input  logic [NSTG-1:0]      stg_rf_wena,
  input  logic [NSTG-1:0]      stg_rf_ready,
  input  logic [NSTG-1:0]      stg_hi_wena,
  input  logic [NSTG-1:0]      stg_lo_wena,
  input  logic [5*NSTG-1:0]    stg_rf_waddr,
  input  logic [XLEN*NSTG-1:0] stg_rf_wdata,
  input  logic [XLEN*NSTG-1:0] stg_hi_wdata,
  input  logic [XLEN*NSTG-1:0] stg_lo_wdata,
  output logic [XLEN-1:0]      rs_data,
  output logic [XLEN-1:0]      rt_data,
  output logic [XLEN-1:0]      hi_data,
  output logic [XLEN-1:0]      lo_data,
  output logic                 stall,
  output logic                 mdu_busy,
  output logic [31:0]          stall_cnt
);

  mdu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        rs_hz, rt_hz, mdu_hz, issue;

  df_port_sel #(.XLEN(XLEN), .NSTG(NSTG)) u_rs_sel (
    .addr(rs_addr), .rena(rs_rena), .rf_data(rs_rf),
    .stg_valid(stg_valid), .stg_rf_wena(stg_rf_wena), .stg_rf_ready(stg_rf_ready),
    .stg_rf_waddr(stg_rf_waddr), .stg_rf_wdata(stg_rf_wdata),
    .data(rs_data), .hazard(rs_hz)
  );

  df_port_sel #(.XLEN(XLEN), .NSTG(NSTG)) u_rt_sel (
    .addr(rt_addr), .rena(rt_rena), .rf_data(rt_rf),
    .stg_valid(stg_valid), .stg_rf_wena(stg_rf_wena), .stg_rf_ready(stg_rf_ready),
    .stg_rf_waddr(stg_rf_waddr), .stg_rf_wdata(stg_rf_wdata),
    .data(rt_data), .hazard(rt_hz)
  );

  // HI/LO forwarding: youngest valid writer wins, else architectural value
  always_comb begin
    hi_data = hi_reg;
    lo_data = lo_reg;
    for (int i = NSTG - 1; i >= 0; i--) begin
      if (stg_valid[i] && stg_hi_wena[i]) hi_data = stg_hi_wdata[XLEN*i +: XLEN];
      if (stg_valid[i] && stg_lo_wena[i]) lo_data = stg_lo_wdata[XLEN*i +: XLEN];
    end
  end

  // stall combines hazards of the instruction in ID; MDU term vanishes in reset since state is IDLE
  always_comb begin
    mdu_hz   = state_q == MDU_BUSY && (hi_rd || lo_rd || mdu_issue);
    stall    = id_valid && (rs_hz || rt_hz || mdu_hz);
    issue    = id_valid && mdu_issue && !stall;
    mdu_busy = state_q == MDU_BUSY;
  end

  // MDU tracker next state; DONE accepts a new issue exactly like IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q + {31'd0, stall && !(&stall_cnt_q)};
    case (state_q)
      MDU_BUSY: begin
        state_d = cnt_q == '0 ? MDU_DONE : MDU_BUSY;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 32'd1;
      end
      default: begin
        state_d = issue ? MDU_BUSY : MDU_IDLE;
        cnt_d   = !issue ? cnt_q : mdu_div ? 32'(DIV_LAT - 1) : 32'(MUL_LAT - 1);
      end
    endcase
  end

  // state registers, cleared asynchronously to abort any in-flight MDU tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MDU_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_unit.sv
// tb_id_hazard_unit: directed stimulus with queued expectations checked by a negedge monitor
module tb_id_hazard_unit;
  localparam int XLEN = 32;
  localparam int NSTG = 2;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int S_RS = 0, S_RT = 1, S_HI = 2, S_LO = 3, S_STALL = 4, S_BUSY = 5, S_CNT = 6;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;
  logic clk = 1'b0;
  logic rst;
  logic id_valid, rs_rena, rt_rena, hi_rd, lo_rd, mdu_issue, mdu_div;
  logic [4:0] rs_addr, rt_addr;
  logic [XLEN-1:0] rs_rf, rt_rf, hi_reg, lo_reg;
  logic [NSTG-1:0] stg_valid, stg_rf_wena, stg_rf_ready, stg_hi_wena, stg_lo_wena;
  logic [5*NSTG-1:0] stg_rf_waddr;
  logic [XLEN*NSTG-1:0] stg_rf_wdata, stg_hi_wdata, stg_lo_wdata;
  logic [XLEN-1:0] rs_data, rt_data, hi_data, lo_data;
  logic stall, mdu_busy;
  logic [31:0] stall_cnt;
  chk_t q[$];
  chk_t c;
  int n_chk = 0;
  int n_err = 0;
  logic stall_exp = 1'b0;
  logic [31:0] exp_sc = '0;
  logic [31:0] a;
  logic done = 1'b0;
  always #5 clk = ~clk;
  id_hazard_unit #(.XLEN(XLEN), .NSTG(NSTG), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_rena(rs_rena), .rt_rena(rt_rena),
    .rs_rf(rs_rf), .rt_rf(rt_rf), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .hi_reg(hi_reg), .lo_reg(lo_reg), .mdu_issue(mdu_issue), .mdu_div(mdu_div),
    .stg_valid(stg_valid), .stg_rf_wena(stg_rf_wena), .stg_rf_ready(stg_rf_ready),
    .stg_hi_wena(stg_hi_wena), .stg_lo_wena(stg_lo_wena),
    .stg_rf_waddr(stg_rf_waddr), .stg_rf_wdata(stg_rf_wdata),
    .stg_hi_wdata(stg_hi_wdata), .stg_lo_wdata(stg_lo_wdata),
    .rs_data(rs_data), .rt_data(rt_data), .hi_data(hi_data), .lo_data(lo_data),
    .stall(stall), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );
  function automatic logic [31:0] act(int s);
    case (s)
      S_RS:    return rs_data;
      S_RT:    return rt_data;
      S_HI:    return hi_data;
      S_LO:    return lo_data;
      S_STALL: return {31'd0, stall};
      S_BUSY:  return {31'd0, mdu_busy};
      default: return stall_cnt;
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      c = q.pop_front();
      a = act(c.sel);
      n_chk++;
      if (a !== c.exp) begin
        n_err++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", c.name, a, c.exp, $time);
      end
    end
  end
  task automatic chk_now(string n, logic [31:0] g, logic [31:0] e);
    n_chk++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, g, e, $time);
    end
  endtask
  initial begin
    repeat (1000) @(posedge clk);
    if (!done) begin
      n_err++;
      $display("FAIL timeout: wait expired at %0t", $time);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
    end
  end
  task automatic push(string n, int s, logic [31:0] e);
    q.push_back('{n, s, e});
    if (s == S_STALL) stall_exp = e[0];
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) exp_sc = '0;
    else if (stall_exp && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    stall_exp = 1'b0;
    #1;
  endtask
  task automatic clr();
    id_valid = 0; rs_rena = 0; rt_rena = 0; hi_rd = 0; lo_rd = 0; mdu_issue = 0; mdu_div = 0;
    rs_addr = 0; rt_addr = 0; rs_rf = 0; rt_rf = 0; hi_reg = 0; lo_reg = 0;
    stg_valid = 0; stg_rf_wena = 0; stg_rf_ready = 0; stg_hi_wena = 0; stg_lo_wena = 0;
    stg_rf_waddr = 0; stg_rf_wdata = 0; stg_hi_wdata = 0; stg_lo_wdata = 0;
  endtask
  task automatic set_rf(int i, logic rdy, logic [4:0] ad, logic [XLEN-1:0] d);
    stg_valid[i] = 1'b1;
    stg_rf_wena[i] = 1'b1;
    stg_rf_ready[i] = rdy;
    stg_rf_waddr[5*i +: 5] = ad;
    stg_rf_wdata[XLEN*i +: XLEN] = d;
  endtask
  initial begin
    rst = 1'b0;
    clr();
    #1;
    chk_now("rst_now_busy", {31'd0, mdu_busy}, 0);
    chk_now("rst_now_stall", {31'd0, stall}, 0);
    chk_now("rst_now_cnt", stall_cnt, 0);
    id_valid = 1; rs_addr = 5; rs_rena = 1; rs_rf = 32'h99;
    set_rf(0, 1, 5, 32'h11);
    push("rst_rs_fwd", S_RS, 32'h11);
    push("rst_stall", S_STALL, 0);
    push("rst_busy", S_BUSY, 0);
    push("rst_cnt", S_CNT, 0);
    tick();
    rst = 1'b1;
    set_rf(1, 1, 5, 32'h22);
    rt_addr = 9; rt_rena = 1; rt_rf = 32'h77;
    push("fwd_youngest", S_RS, 32'h11);
    push("rt_no_match", S_RT, 32'h77);
    push("fwd_stall", S_STALL, 0);
    tick();
    stg_valid[0] = 0;
    push("fwd_older", S_RS, 32'h22);
    tick();
    rs_rena = 0;
    push("rena_off", S_RS, 32'h99);
    tick();
    clr();
    id_valid = 1; rt_addr = 7; rt_rena = 1; rt_rf = 32'h1;
    set_rf(0, 0, 7, 32'h55);
    set_rf(1, 1, 7, 32'h66);
    push("lu_rt", S_RT, 32'h55);
    push("lu_stall", S_STALL, 1);
    push("lu_cnt0", S_CNT, 0);
    tick();
    stg_valid[0] = 0;
    set_rf(1, 1, 7, 32'h77);
    push("lu_rel_rt", S_RT, 32'h77);
    push("lu_rel_stall", S_STALL, 0);
    push("lu_cnt1", S_CNT, 1);
    tick();
    id_valid = 0;
    set_rf(0, 0, 7, 32'h55);
    push("noid_stall", S_STALL, 0);
    push("noid_rt", S_RT, 32'h55);
    tick();
    clr();
    id_valid = 1; rs_addr = 0; rs_rena = 1; rs_rf = 0;
    set_rf(0, 0, 0, 32'hDEAD);
    push("r0_rs", S_RS, 0);
    push("r0_stall", S_STALL, 0);
    tick();
    clr();
    hi_reg = 1; lo_reg = 2;
    stg_valid = 2'b11;
    stg_hi_wena[1] = 1; stg_hi_wdata[XLEN +: XLEN] = 32'hAAAA;
    stg_lo_wena[0] = 1; stg_lo_wdata[0 +: XLEN] = 32'hBBBB;
    push("hi_mem", S_HI, 32'hAAAA);
    push("lo_exe", S_LO, 32'hBBBB);
    push("hilo_stall", S_STALL, 0);
    tick();
    stg_hi_wena[0] = 1; stg_hi_wdata[0 +: XLEN] = 32'hCCCC;
    push("hi_exe", S_HI, 32'hCCCC);
    tick();
    stg_valid = 0;
    push("hi_reg", S_HI, 1);
    push("lo_reg", S_LO, 2);
    tick();
    clr();
    id_valid = 1; mdu_issue = 1; mdu_div = 1;
    push("div_issue_stall", S_STALL, 0);
    push("div_issue_busy", S_BUSY, 0);
    tick();
    mdu_issue = 0; mdu_div = 0; lo_rd = 1;
    for (int k = 0; k < DIV_LAT; k++) begin
      push($sformatf("div_stall_%0d", k), S_STALL, 1);
      push($sformatf("div_busy_%0d", k), S_BUSY, 1);
      tick();
    end
    mdu_issue = 1;
    push("done_stall", S_STALL, 0);
    push("done_busy", S_BUSY, 0);
    push("div_cnt", S_CNT, 1 + DIV_LAT);
    tick();
    clr();
    push("mul_busy1", S_BUSY, 1);
    push("mul_idle_stall", S_STALL, 0);
    tick();
    id_valid = 1; hi_rd = 1;
    rst = 1'b0;
    #1;
    exp_sc = '0;
    push("abort_busy", S_BUSY, 0);
    push("abort_stall", S_STALL, 0);
    push("abort_cnt", S_CNT, 0);
    tick();
    rst = 1'b1;
    push("post_rst_busy", S_BUSY, 0);
    push("post_rst_stall", S_STALL, 0);
    push("post_rst_cnt", S_CNT, 0);
    tick();
    clr();
    id_valid = 1; rt_addr = 7; rt_rena = 1;
    set_rf(0, 0, 7, 32'h55);
    force dut.stall_cnt_d = 32'hFFFF_FFFE;
    push("sat_stall", S_STALL, 1);
    tick();
    release dut.stall_cnt_d;
    exp_sc = 32'hFFFF_FFFE;
    push("sat_pre", S_CNT, 32'hFFFF_FFFE);
    push("sat_stall2", S_STALL, 1);
    tick();
    push("sat_max", S_CNT, 32'hFFFF_FFFF);
    push("sat_stall3", S_STALL, 1);
    tick();
    push("sat_hold", S_CNT, 32'hFFFF_FFFF);
    push("sat_model", S_CNT, exp_sc);
    tick();
    @(negedge clk);
    #1;
    chk_now("sat_final", stall_cnt, exp_sc);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
